posit_add_result_checker: RTL and testbench

Streaming result checker for the posit adder verification flow, sitting at the output end of the adder datapath. Consumes adder results over a valid/ready handshake and fetches the expected posit for each vector index from a synchronous-read golden memory. Computes the unsigned absolute difference per vector and accumulates error statistics, so exhaustive 8-bit runs are scored in hardware rather than post-processed from a diff file.

---
 rtl/posit_add_result_checker.sv | 137 +++++++++++++
 tb/tb_posit_add_result_checker.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/posit_add_result_checker.sv
// Streaming scorer for posit adder results: fetches the golden word per vector index,
// takes the absolute difference against the adder output and accumulates run statistics.
module posit_add_result_checker #(
    parameter int N       = 8,
    parameter int AW      = 16,
    parameter int NUM_VEC = 65535,
    parameter int TOL     = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          res_valid,
    input  logic [N-1:0]  res_data,
    output logic          res_ready,
    output logic          exp_rd,
    output logic [AW-1:0] exp_addr,
    input  logic [N-1:0]  exp_data,
    output logic          busy,
    output logic          done,
    output logic          diff_valid,
    output logic [N-1:0]  diff_out,
    output logic [AW-1:0] err_cnt,
    output logic [AW-1:0] tol_cnt,
    output logic [N-1:0]  max_diff,
    output logic [AW-1:0] first_err_idx,
    output logic          first_err_vld
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_CMP,
        S_DONE
    } state_t;

    localparam logic [N-1:0]  TOL_W    = N'(TOL);
    localparam logic [AW-1:0] LAST_IDX = AW'(NUM_VEC - 1);
    localparam logic [AW-1:0] CNT_MAX  = {AW{1'b1}};

    state_t        state_q;
    state_t        state_d;
    logic [AW-1:0] idx_q;
    logic [N-1:0]  exp_q;
    logic [N-1:0]  diff_c;
    logic          xfer;
    logic          last;
    logic          start_ok;

    // Magnitude of the difference between two unsigned posit bit patterns, no wrap.
    function automatic logic [N-1:0] abs_diff(input logic [N-1:0] a, input logic [N-1:0] b);
        return (a > b) ? (a - b) : (b - a);
    endfunction

    function automatic logic [AW-1:0] sat_inc(input logic [AW-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

    assign xfer     = (state_q == S_CMP) && res_valid;
    assign last     = (idx_q == LAST_IDX);
    assign start_ok = start && ((state_q == S_IDLE) || (state_q == S_DONE));
    assign diff_c   = abs_diff(exp_q, res_data);

    assign res_ready = (state_q == S_CMP);
    assign exp_rd    = (state_q == S_FETCH);
    assign exp_addr  = idx_q;
    assign busy      = (state_q == S_FETCH) || (state_q == S_WAIT) || (state_q == S_CMP);
    assign done      = (state_q == S_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_FETCH;
            S_FETCH: state_d = S_WAIT;
            S_WAIT:  state_d = S_CMP;
            S_CMP:   if (res_valid) state_d = last ? S_DONE : S_FETCH;
            S_DONE:  if (start) state_d = S_FETCH;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q         <= '0;
            exp_q         <= '0;
            diff_valid    <= 1'b0;
            diff_out      <= '0;
            err_cnt       <= '0;
            tol_cnt       <= '0;
            max_diff      <= '0;
            first_err_idx <= '0;
            first_err_vld <= 1'b0;
        end else begin
            diff_valid <= xfer;
            if (start_ok) begin
                idx_q         <= '0;
                err_cnt       <= '0;
                tol_cnt       <= '0;
                max_diff      <= '0;
                first_err_idx <= '0;
                first_err_vld <= 1'b0;
            end
            // Golden word arrives the cycle after the read strobe.
            if (state_q == S_WAIT) begin
                exp_q <= exp_data;
            end
            if (xfer) begin
                diff_out <= diff_c;
                if (diff_c != '0) begin
                    err_cnt <= sat_inc(err_cnt);
                    if (!first_err_vld) begin
                        first_err_idx <= idx_q;
                        first_err_vld <= 1'b1;
                    end
                end
                if (diff_c > TOL_W) begin
                    tol_cnt <= sat_inc(tol_cnt);
                end
                if (diff_c > max_diff) begin
                    max_diff <= diff_c;
                end
                if (!last) begin
                    idx_q <= idx_q + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_posit_add_result_checker.sv
// Bench for posit_add_result_checker: table vectors, randomized runs against a
// plain-arithmetic scoring model, stall/start/reset corner sequences, small-AW instance.
module tb_posit_add_result_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        start_a, start_b;
    logic        res_valid_a, res_valid_b;
    logic [7:0]  res_data_a, res_data_b;
    logic [7:0]  exp_data_a, exp_data_b;

    logic        res_ready_a, exp_rd_a, busy_a, done_a, diff_valid_a, first_err_vld_a;
    logic [15:0] exp_addr_a, err_cnt_a, tol_cnt_a, first_err_idx_a;
    logic [7:0]  diff_out_a, max_diff_a;

    logic        res_ready_b, exp_rd_b, busy_b, done_b, diff_valid_b, first_err_vld_b;
    logic [2:0]  exp_addr_b, err_cnt_b, tol_cnt_b, first_err_idx_b;
    logic [7:0]  diff_out_b, max_diff_b;

    posit_add_result_checker #(.N(8), .AW(16), .NUM_VEC(4), .TOL(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a),
        .res_valid(res_valid_a), .res_data(res_data_a), .res_ready(res_ready_a),
        .exp_rd(exp_rd_a), .exp_addr(exp_addr_a), .exp_data(exp_data_a),
        .busy(busy_a), .done(done_a), .diff_valid(diff_valid_a), .diff_out(diff_out_a),
        .err_cnt(err_cnt_a), .tol_cnt(tol_cnt_a), .max_diff(max_diff_a),
        .first_err_idx(first_err_idx_a), .first_err_vld(first_err_vld_a)
    );

    posit_add_result_checker #(.N(8), .AW(3), .NUM_VEC(7), .TOL(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b),
        .res_valid(res_valid_b), .res_data(res_data_b), .res_ready(res_ready_b),
        .exp_rd(exp_rd_b), .exp_addr(exp_addr_b), .exp_data(exp_data_b),
        .busy(busy_b), .done(done_b), .diff_valid(diff_valid_b), .diff_out(diff_out_b),
        .err_cnt(err_cnt_b), .tol_cnt(tol_cnt_b), .max_diff(max_diff_b),
        .first_err_idx(first_err_idx_b), .first_err_vld(first_err_vld_b)
    );

    // Golden memories: synchronous read, junk on cycles without a read strobe.
    logic [7:0] gold_a [4];
    logic [7:0] res_a  [4];
    logic [7:0] gold_b [8];
    logic [7:0] res_b  [8];

    always @(posedge clk) begin
        exp_data_a <= exp_rd_a ? gold_a[exp_addr_a[1:0]] : 8'($urandom);
        exp_data_b <= exp_rd_b ? gold_b[exp_addr_b] : 8'($urandom);
    end

    int checks = 0;
    int fails  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int absd(input int g, input int r);
        int d;
        d = g - r;
        if (d < 0) d = -d;
        return d;
    endfunction

    // Reference scoring of a whole run from the golden/result arrays.
    task automatic model_a(output int e, output int t, output int m, output int fi, output int fv);
        e = 0; t = 0; m = 0; fi = 0; fv = 0;
        for (int i = 0; i < 4; i++) begin
            int d;
            d = absd(gold_a[i], res_a[i]);
            if (d != 0) begin
                if (e < 65535) e++;
                if (fv == 0) begin fi = i; fv = 1; end
            end
            if (d > 1 && t < 65535) t++;
            if (d > m) m = d;
        end
    endtask

    task automatic pulse_start_a();
        @(negedge clk) start_a = 1'b1;
        @(negedge clk) start_a = 1'b0;
    endtask

    // Wait for CMP (junk valid while not ready), optional stalls, then transfer vector i.
    task automatic xfer_a(input int i, input int stall, input bit mid_start, output bit ok);
        int n;
        n = 0;
        ok = 1'b0;
        while (!res_ready_a && n < 10) begin
            res_valid_a = 1'($urandom);
            res_data_a  = 8'($urandom);
            @(negedge clk);
            n++;
        end
        res_valid_a = 1'b0;
        if (!res_ready_a) begin
            chk("ready_timeout", 0, 1);
            return;
        end
        chk("exp_addr", exp_addr_a, i);
        for (int s = 0; s < stall; s++) begin
            logic [15:0] pre_err;
            logic [7:0]  pre_max;
            pre_err = err_cnt_a;
            pre_max = max_diff_a;
            if (mid_start && s == 0) start_a = 1'b1;
            @(negedge clk);
            start_a = 1'b0;
            chk("stall_ready", res_ready_a, 1);
            chk("stall_no_dv", diff_valid_a, 0);
            chk("stall_err_hold", err_cnt_a, pre_err);
            chk("stall_max_hold", max_diff_a, pre_max);
            chk("stall_addr", exp_addr_a, i);
        end
        res_valid_a = 1'b1;
        res_data_a  = res_a[i];
        @(negedge clk);
        res_valid_a = 1'b0;
        res_data_a  = 8'($urandom);
        chk("diff_valid", diff_valid_a, 1);
        chk("diff_out", diff_out_a, absd(gold_a[i], res_a[i]));
        @(negedge clk);
        chk("dv_one_cycle", diff_valid_a, 0);
        ok = 1'b1;
    endtask

    task automatic run_a(input int e, input int t, input int m, input int fi, input int fv,
                         input int max_stall, input bit mid_start);
        bit ok;
        pulse_start_a();
        chk("busy_after_start", busy_a, 1);
        chk("done_after_start", done_a, 0);
        chk("err_cleared", err_cnt_a, 0);
        chk("fv_cleared", first_err_vld_a, 0);
        for (int i = 0; i < 4; i++) begin
            xfer_a(i, (max_stall > 0) ? $urandom_range(0, max_stall) : 0, mid_start, ok);
            if (!ok) return;
        end
        chk("done", done_a, 1);
        chk("busy_done", busy_a, 0);
        chk("ready_done", res_ready_a, 0);
        chk("err_cnt", err_cnt_a, e);
        chk("tol_cnt", tol_cnt_a, t);
        chk("max_diff", max_diff_a, m);
        chk("first_err_vld", first_err_vld_a, fv);
        if (fv != 0) chk("first_err_idx", first_err_idx_a, fi);
    endtask

    typedef struct {
        logic [31:0] g;
        logic [31:0] r;
        int err;
        int tol;
        int mx;
        int fi;
        int fv;
    } vec_t;

    vec_t tbl [5];

    initial begin
        bit ok;
        int e, t, m, fi, fv;

        tbl[0] = '{32'h40302010, 32'h40302010, 0, 0, 8'h00, 0, 0};
        tbl[1] = '{32'h40302010, 32'h40322010, 1, 1, 8'h02, 2, 1};
        tbl[2] = '{32'h80004001, 32'h80003FFF, 2, 1, 8'hFE, 0, 1};
        tbl[3] = '{32'h807FFF00, 32'h7F8000FF, 4, 2, 8'hFF, 0, 1};
        tbl[4] = '{32'h00000000, 32'h00010000, 1, 0, 8'h01, 2, 1};

        rst_n = 1'b0; start_a = 0; start_b = 0;
        res_valid_a = 0; res_valid_b = 0; res_data_a = 0; res_data_b = 0;
        for (int i = 0; i < 4; i++) begin gold_a[i] = 0; res_a[i] = 0; end
        for (int i = 0; i < 8; i++) begin gold_b[i] = 8'(i * 3); res_b[i] = 8'(i * 3) ^ 8'h80; end
        repeat (3) @(negedge clk);
        chk("rst_busy", busy_a, 0);
        chk("rst_done", done_a, 0);
        chk("rst_ready", res_ready_a, 0);
        chk("rst_exp_rd", exp_rd_a, 0);
        chk("rst_addr", exp_addr_a, 0);
        chk("rst_err", err_cnt_a, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_busy", busy_a, 0);

        for (int k = 0; k < 5; k++) begin
            for (int i = 0; i < 4; i++) begin
                gold_a[i] = tbl[k].g[8*i +: 8];
                res_a[i]  = tbl[k].r[8*i +: 8];
            end
            run_a(tbl[k].err, tbl[k].tol, tbl[k].mx, tbl[k].fi, tbl[k].fv, 0, 1'b0);
        end

        // Long stall with start pulsed mid-run.
        gold_a = '{8'h11, 8'h22, 8'h33, 8'h44};
        res_a  = '{8'h11, 8'h25, 8'h33, 8'h44};
        pulse_start_a();
        xfer_a(0, 5, 1'b1, ok);
        xfer_a(1, 5, 1'b1, ok);
        xfer_a(2, 0, 1'b0, ok);
        xfer_a(3, 0, 1'b0, ok);
        chk("stall_run_done", done_a, 1);
        chk("stall_run_err", err_cnt_a, 1);
        chk("stall_run_fi", first_err_idx_a, 1);

        for (int k = 0; k < 20; k++) begin
            for (int i = 0; i < 4; i++) begin
                int off;
                gold_a[i] = 8'($urandom);
                case ($urandom_range(0, 4))
                    0, 1: off = 0;
                    2: off = 1;
                    3: off = -2;
                    default: off = int'($urandom_range(0, 255));
                endcase
                res_a[i] = 8'(int'(gold_a[i]) + off);
            end
            model_a(e, t, m, fi, fv);
            run_a(e, t, m, fi, fv, 3, k[0]);
        end

        // Small-counter instance: every vector mismatched.
        @(negedge clk) start_b = 1'b1;
        @(negedge clk) start_b = 1'b0;
        for (int i = 0; i < 7; i++) begin
            int n;
            n = 0;
            while (!res_ready_b && n < 10) begin @(negedge clk); n++; end
            if (!res_ready_b) begin chk("b_ready_timeout", 0, 1); break; end
            res_valid_b = 1'b1;
            res_data_b  = res_b[i];
            @(negedge clk);
            res_valid_b = 1'b0;
            chk("b_diff_out", diff_out_b, 8'h80);
        end
        chk("b_err_sat", err_cnt_b, 7);
        chk("b_tol_sat", tol_cnt_b, 7);
        chk("b_max", max_diff_b, 8'h80);
        chk("b_fv", first_err_vld_b, 1);
        chk("b_fi", first_err_idx_b, 0);
        chk("b_done", done_b, 1);
        repeat (2) @(negedge clk);
        chk("b_done_held", done_b, 1);
        chk("b_err_held", err_cnt_b, 7);
        @(negedge clk) start_b = 1'b1;
        @(negedge clk) start_b = 1'b0;
        chk("b_restart_done", done_b, 0);
        chk("b_restart_err", err_cnt_b, 0);
        chk("b_restart_tol", tol_cnt_b, 0);
        chk("b_restart_max", max_diff_b, 0);
        chk("b_restart_fv", first_err_vld_b, 0);
        chk("b_restart_addr", exp_addr_b, 0);
        chk("b_restart_busy", busy_b, 1);

        // Async reset while waiting on the golden word for vector 2.
        gold_a = '{8'h10, 8'h20, 8'h30, 8'h40};
        res_a  = '{8'h18, 8'h20, 8'h30, 8'h40};
        pulse_start_a();
        xfer_a(0, 0, 1'b0, ok);
        xfer_a(1, 0, 1'b0, ok);
        chk("pre_rst_addr", exp_addr_a, 2);
        chk("pre_rst_busy", busy_a, 1);
        chk("pre_rst_err", err_cnt_a, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_busy", busy_a, 0);
        chk("arst_addr", exp_addr_a, 0);
        chk("arst_exp_rd", exp_rd_a, 0);
        chk("arst_err", err_cnt_a, 0);
        chk("arst_tol", tol_cnt_a, 0);
        chk("arst_max", max_diff_a, 0);
        chk("arst_diff_out", diff_out_a, 0);
        chk("arst_fv", first_err_vld_a, 0);
        chk("arst_fi", first_err_idx_a, 0);
        chk("arst_b_busy", busy_b, 0);
        @(negedge clk) rst_n = 1'b1;
        pulse_start_a();
        chk("restart_addr", exp_addr_a, 0);
        chk("restart_exp_rd", exp_rd_a, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
